// File: rtl/multi_dice.sv
// Bank of NUM_DICE odometer-chained dice of FACES faces each, rolled while `button` is high.
// On release it registers the sum of the frozen dice, strobes `done` and bumps a saturating count.
module multi_dice #(
  parameter int unsigned FACES    = 6,
  parameter int unsigned NUM_DICE = 2,
  parameter int unsigned CW       = 8,
  localparam int unsigned W       = $clog2(FACES + 1),
  localparam int unsigned SW      = $clog2(NUM_DICE * FACES + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  button,
  input  logic [NUM_DICE-1:0]   hold,
  output logic [NUM_DICE*W-1:0] throw,
  output logic [SW-1:0]         sum,
  output logic                  done,
  output logic [CW-1:0]         roll_count
);

  localparam logic [W-1:0] FaceMax = W'(FACES);
  localparam logic [W-1:0] FaceOne = W'(1);

  typedef enum logic [0:0] {StIdle, StRoll} state_e;

  state_e                       state_q, state_d;
  logic [NUM_DICE-1:0][W-1:0]   dice_q, dice_d;
  logic [SW-1:0]                sum_q, sum_d, total;
  logic [CW-1:0]                count_q, count_d;
  logic                         done_q, done_d;
  logic                         carry;
  logic                         throw_end;

  // Carry ripples through the chain in one pass; held dice forward it untouched.
  always_comb begin
    dice_d = dice_q;
    carry  = 1'b1;
    for (int i = 0; i < int'(NUM_DICE); i++) begin
      if (dice_q[i] == '0 || 32'(dice_q[i]) > FACES) begin
        dice_d[i] = FaceOne;
        carry     = 1'b0;
      end else if (hold[i]) begin
        carry = carry;
      end else if (button && carry) begin
        if (dice_q[i] == FaceMax) begin
          dice_d[i] = FaceOne;
          carry     = 1'b1;
        end else begin
          dice_d[i] = dice_q[i] + FaceOne;
          carry     = 1'b0;
        end
      end else begin
        carry = 1'b0;
      end
    end
  end

  always_comb begin
    total = '0;
    for (int i = 0; i < int'(NUM_DICE); i++) begin
      total = total + SW'(dice_q[i]);
    end
  end

  always_comb begin
    state_d   = state_q;
    throw_end = 1'b0;
    unique case (state_q)
      StIdle: if (button) state_d = StRoll;
      StRoll: begin
        if (!button) begin
          state_d   = StIdle;
          throw_end = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    done_d  = throw_end;
    sum_d   = sum_q;
    count_d = count_q;
    if (throw_end) begin
      sum_d = total;
      if (count_q != {CW{1'b1}}) count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      dice_q  <= '0;
      sum_q   <= '0;
      done_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      dice_q  <= dice_d;
      sum_q   <= sum_d;
      done_q  <= done_d;
      count_q <= count_d;
    end
  end

  assign throw      = dice_q;
  assign sum        = sum_q;
  assign done       = done_q;
  assign roll_count = count_q;

endmodule

// File: doc/multi_dice.md
# multi_dice

Parametrised electronic dice bank, the next generation of the single six-sided die. It runs NUM_DICE dice of FACES faces each. The dice roll odometer-fashion while `button` is high and freeze when it is released. Individual dice can be held between throws. On every release the block reports the registered sum of all dice, a one-cycle `done` strobe and a saturating count of completed throws. It sits between the debounced push-button logic and the display/scoring logic.

## Interface
- FACES, 6, faces per die; legal range 2..255; face values run 1..FACES.
- NUM_DICE, 2, number of dice; legal range 1..8.
- CW, 8, width of `roll_count`.
- W (derived, not overridable), $clog2(FACES+1), bits per die.
- SW (derived), $clog2(NUM_DICE*FACES+1), width of `sum`.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- button  in  1  roll request, synchronous to clk, already debounced.
- hold  in  NUM_DICE  bit i = 1 freezes die i.
- throw  out  NUM_DICE*W  die i occupies bits [i*W +: W].
- sum  out  SW  sum of all dice, captured at end of throw.
- done  out  1  one-cycle strobe, throw finished.
- roll_count  out  CW  completed throws, saturating.

## Operation
- Reset (rst low, asynchronous) clears outputs and state:
  - every die, `sum`, `done` and `roll_count` go to 0;
  - FSM goes to IDLE.
- Invalid-value recovery has priority over everything except reset. Any die holding 0 or a value above FACES loads 1 on the next edge, regardless of `button` or `hold`. Consequently all dice read 1 one cycle after reset release.
- Carry chain (evaluated each edge while `button` = 1):
  - carry-in of die 0 = 1;
  - a non-held, valid die with carry-in 1 steps: FACES goes to 1, otherwise value + 1;
  - carry-out of that die = 1 only when it wraps FACES to 1, else 0;
  - a held die keeps its value and passes its carry-in unchanged to die i+1.
- While `button` = 0, valid dice keep their value.
- FSM states:
  - IDLE: go to ROLL when `button` = 1.
  - ROLL: go to IDLE when `button` = 0 (release detected).
- On the edge that performs the ROLL→IDLE transition:
  - `done` is set for exactly one cycle;
  - `sum` loads the zero-extended SW-bit sum of all dice values present before that edge, i.e. the frozen final throw;
  - `roll_count` increments, holding at 2^CW−1 once reached.
- `sum` holds its value until the next release; it does not track rolling dice.
- `hold` changes take effect on the next edge.
- If all dice are held, a press/release still produces `done`, updates `sum` and increments the count.

## Timing
- Button high sampled at edge t:
  - dice first step at edge t, moving from IDLE into ROLL;
  - die 0 changes every cycle thereafter.
- Button low first sampled at edge r:
  - dice do not step at r;
  - at edge r: FSM returns to IDLE, `done` = 1 and `sum` is valid;
  - at edge r+1: `done` = 0.
- A one-cycle button pulse (high at t only) steps die 0 once, then gives `done` at t+1.
- Latency from the last die step to `sum` valid is one cycle.
- Reset asserted mid-throw clears everything immediately. There is no `done`, and `roll_count` is not incremented.
- Dice wrap and carry in the same edge; there is no extra cycle per carry stage.

## Test plan
- Reset and recovery (FACES=6, NUM_DICE=2):
  - during reset: throw = 0, sum = 0, done = 0, roll_count = 0;
  - one cycle after release: both dice = 1.
- Button held 6 cycles from {1,1}:
  - die 0 goes 2,3,4,5,6,1 and die 1 becomes 2 on the wrap edge;
  - on release: done pulses once, sum = 3, roll_count = 1.
- Hold die 0 at 4 (hold = 2'b01), press 3 cycles:
  - die 0 stays 4 and die 1 advances 3 steps via the passed carry;
  - done strobe, sum = 4 + die 1.
- FACES=255, NUM_DICE=8: roll long enough for all dice to sit at 255, then release:
  - sum = 2040, no overflow (SW = 11).
- CW=2: complete 5 throws:
  - roll_count goes 1, 2, 3, 3, 3;
  - done pulses 5 times.
- Reset asserted during ROLL:
  - immediate clear, no done pulse;
  - first press after recovery behaves as in scenario 2.
